// File: rtl/snake_reset_pkg.sv
// rtl/snake_reset_pkg.sv - state encoding, default parameters and counter sizing for reset_sequencer
package snake_reset_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_e;

    localparam int DEF_NUM_STAGES      = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_HOLD_CYCLES     = 16;
    localparam int DEF_TIMEOUT_CYCLES  = 1000000;

    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/reset_debounce.sv
// rtl/reset_debounce.sv - synchroniser and debouncer for the SW9 slider, 1-cycle req per accepted toggle
module reset_debounce
    import snake_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic req
);
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [1:0]    vld_q, vld_d;
    logic          init_q, init_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            vld_q   <= 2'b00;
            init_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            init_q  <= init_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // vld_q marks when sync_q[1] first holds a real sample, so the boot level is adopted silently
    always_comb begin
        sync_d  = {sync_q[0], raw_in};
        vld_d   = {vld_q[0], 1'b1};
        init_d  = init_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        if (!init_q) begin
            if (vld_q[1]) begin
                level_d = sync_q[1];
                init_d  = 1'b1;
            end
        end else if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            cnt_d   = '0;
            req_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign req = req_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered, ready-handshaked release of subsystem resets from the SW9 slider
// Optional STAGE_TIMEOUT_EN: a stage whose ready never arrives is skipped after TIMEOUT_CYCLES.
module reset_sequencer
    import snake_reset_pkg::*;
#(
    parameter int NUM_STAGES      = DEF_NUM_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  resetHW,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  sys_ready,
    output logic                  busy,
    output logic                  timeout_flag
);
    localparam int            KW        = cnt_width(NUM_STAGES - 1);
    localparam int            HW        = cnt_width(HOLD_CYCLES);
    localparam logic [KW-1:0] K_LAST    = KW'(NUM_STAGES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    seq_state_e            state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
    logic                  busy_q, busy_d;
    logic                  sys_ready_q, sys_ready_d;
    logic                  req;
    logic                  advance;

    reset_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock (clock),
        .reset (reset),
        .raw_in(resetHW),
        .req   (req)
    );

`ifdef STAGE_TIMEOUT_EN
    localparam int            TW      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_q, to_d;
    logic          timeout_q, timeout_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_q      <= to_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_flag = timeout_q;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
    assign timeout_flag   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_ASSERT;
            k_q           <= '0;
            hold_q        <= '0;
            stage_reset_q <= '1;
            busy_q        <= 1'b1;
            sys_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            hold_q        <= hold_d;
            stage_reset_q <= stage_reset_d;
            busy_q        <= busy_d;
            sys_ready_q   <= sys_ready_d;
        end
    end

    // A debounced toggle restarts from any state and beats a same-cycle stage_ready
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        hold_d  = hold_q;
        advance = 1'b0;
`ifdef STAGE_TIMEOUT_EN
        to_d      = to_q;
        timeout_d = timeout_q;
`endif
        if (req) begin
            state_d = ST_ASSERT;
            k_d     = '0;
            hold_d  = '0;
`ifdef STAGE_TIMEOUT_EN
            to_d      = '0;
            timeout_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_RELEASE;
                        k_d     = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                ST_RELEASE: begin
                    advance = stage_ready[k_q];
`ifdef STAGE_TIMEOUT_EN
                    if (!advance) begin
                        if (to_q == TO_LAST) begin
                            advance   = 1'b1;
                            timeout_d = 1'b1;
                        end else begin
                            to_d = to_q + TW'(1);
                        end
                    end
                    if (advance) begin
                        to_d = '0;
                    end
`endif
                    if (advance) begin
                        if (k_q == K_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end
                end
                ST_DONE: state_d = ST_RUN;
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_ASSERT;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered yet change with the state
    always_comb begin
        stage_reset_d = '0;
        busy_d        = 1'b1;
        sys_ready_d   = 1'b0;
        case (state_d)
            ST_ASSERT: stage_reset_d = '1;
            ST_RELEASE: begin
                for (int i = 0; i < NUM_STAGES; i++) begin
                    stage_reset_d[i] = (i > int'(k_d));
                end
            end
            ST_DONE: busy_d = 1'b0;
            ST_RUN: begin
                busy_d      = 1'b0;
                sys_ready_d = 1'b1;
            end
            default: stage_reset_d = '1;
        endcase
    end

    assign stage_reset = stage_reset_q;
    assign busy        = busy_q;
    assign sys_ready   = sys_ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer (cold boot, debounce, handshake, restart, timeout, async reset)
module tb_reset_sequencer;

    typedef struct {
        int         cyc;
        logic [5:0] val;
        string      name;
    } exp_t;

    logic       clock       = 1'b0;
    logic       reset       = 1'b0;
    logic       resetHW     = 1'b0;
    logic [2:0] stage_ready = 3'b111;
    logic [2:0] stage_reset;
    logic       sys_ready;
    logic       busy;
    logic       timeout_flag;

    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;
    logic       done  = 1'b0;
    exp_t       exp_q[$];
    logic [5:0] mon_cur;
    logic [5:0] mon_last = 6'bxxxxxx;
    exp_t       mon_e;

    reset_sequencer #(
        .NUM_STAGES     (3),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .resetHW     (resetHW),
        .stage_ready (stage_ready),
        .stage_reset (stage_reset),
        .sys_ready   (sys_ready),
        .busy        (busy),
        .timeout_flag(timeout_flag)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected value packing: {stage_reset[2:0], busy, sys_ready, timeout_flag}
    task automatic expect_at(input int at, input logic [5:0] v, input string nm);
        exp_t e;
        e.cyc  = at;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic expect_seq(input int a, input string nm);
        expect_at(a + 8,  6'b110_1_0_0, {nm, "_rel0"});
        expect_at(a + 9,  6'b100_1_0_0, {nm, "_rel1"});
        expect_at(a + 10, 6'b000_1_0_0, {nm, "_rel2"});
        expect_at(a + 11, 6'b000_0_0_0, {nm, "_done"});
        expect_at(a + 12, 6'b000_0_1_0, {nm, "_run"});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    always @(negedge clock) begin
        mon_cur = {stage_reset, busy, sys_ready, timeout_flag};
        if (mon_cur !== mon_last) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change cyc=%0d got=%b required=none", cyc, mon_cur);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_cur !== mon_e.val || cyc != mon_e.cyc) begin
                    bad++;
                    $display("FAIL %s got=%b@%0d required=%b@%0d", mon_e.name, mon_cur, cyc, mon_e.val, mon_e.cyc);
                end
            end
            mon_last = mon_cur;
        end
        if (done) begin
            while (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL %s got=none required=%b@%0d", mon_e.name, mon_e.val, mon_e.cyc);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        int a;
        int a2;

        expect_at(1, 6'b111_1_0_0, "reset_state");
        tick(5);
        reset = 1'b1;
        a = cyc;
        expect_seq(a, "cold");
        wait_until(a + 15);

        // bouncing 0->1->0->1 at 2-cycle spacing: one req 6 cycles after the last edge
        a = cyc + 4 + 7;
        expect_at(a, 6'b111_1_0_0, "deb_req");
        expect_seq(a, "deb");
        resetHW = 1'b1;
        tick(2);
        resetHW = 1'b0;
        tick(2);
        resetHW = 1'b1;
        wait_until(a + 15);

        // 3-cycle glitch is one short of acceptance
        resetHW = 1'b0;
        tick(3);
        resetHW = 1'b1;
        wait_until(cyc + 12);

        // stage 1 withholds ready for 10 cycles
        stage_ready = 3'b101;
        a = cyc + 7;
        expect_at(a,      6'b111_1_0_0, "hs_req");
        expect_at(a + 8,  6'b110_1_0_0, "hs_rel0");
        expect_at(a + 9,  6'b100_1_0_0, "hs_rel1");
        expect_at(a + 19, 6'b000_1_0_0, "hs_rel2");
        expect_at(a + 20, 6'b000_0_0_0, "hs_done");
        expect_at(a + 21, 6'b000_0_1_0, "hs_run");
        resetHW = 1'b0;
        wait_until(a + 18);
        stage_ready = 3'b111;
        wait_until(a + 25);

        // restart while waiting in stage 1; ready arrives on the same cycle as req
        stage_ready = 3'b101;
        a  = cyc + 7;
        a2 = a + 16;
        expect_at(a,     6'b111_1_0_0, "rs_req");
        expect_at(a + 8, 6'b110_1_0_0, "rs_rel0");
        expect_at(a + 9, 6'b100_1_0_0, "rs_rel1");
        expect_at(a2,    6'b111_1_0_0, "rs_restart");
        expect_seq(a2, "rs");
        resetHW = 1'b1;
        wait_until(a + 9);
        resetHW = 1'b0;
        wait_until(a2 - 1);
        stage_ready = 3'b111;
        wait_until(a2 + 15);

        // stage 2 ready stuck low
        stage_ready = 3'b011;
        a  = cyc + 7;
        a2 = a + 37;
        expect_at(a,      6'b111_1_0_0, "to_req");
        expect_at(a + 8,  6'b110_1_0_0, "to_rel0");
        expect_at(a + 9,  6'b100_1_0_0, "to_rel1");
        expect_at(a + 10, 6'b000_1_0_0, "to_rel2");
`ifdef STAGE_TIMEOUT_EN
        expect_at(a + 26, 6'b000_0_0_1, "to_expire");
        expect_at(a + 27, 6'b000_0_1_1, "to_run");
`endif
        expect_at(a2, 6'b111_1_0_0, "to_clear");
        expect_seq(a2, "to_next");
        resetHW = 1'b1;
        wait_until(a + 30);
        resetHW = 1'b0;
        wait_until(a2);
        stage_ready = 3'b111;
        wait_until(a2 + 15);

        // half-cycle async reset while in RUN
        a = cyc;
        expect_at(a, 6'b111_1_0_0, "arst_assert");
        expect_seq(a, "arst");
        reset = 1'b0;
        #5;
        reset = 1'b1;
        wait_until(a + 20);

        done = 1'b1;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Turns the SW9 hardware reset slider into an ordered, handshaked reset sequence for the Snake design's subsystems, e.g. stage 0 LCD driver, stage 1 frame renderer, stage 2 game engine.
- Synchronises and debounces the raw switch. Any accepted toggle holds all stages in reset, then releases them one at a time, waiting for each stage's ready before the next.
- Sits between the board switch/clock pins and every subsystem reset input.

Parameters:
- NUM_STAGES, 3, number of sequenced subsystem resets.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a new switch level (1 ms at 50 MHz).
- HOLD_CYCLES, 16, cycles all stage resets are held high before the first release.
- TIMEOUT_CYCLES, 1000000, maximum wait for one stage_ready (STAGE_TIMEOUT_EN only).

Ports:
- clock  input  1  system clock.
- reset  input  1  power-on reset; one clock; reset is asynchronous and active-low.
- resetHW  input  1  raw, unsynchronised, undebounced SW9 level.
- stage_ready  input  NUM_STAGES  per-stage "initialised" indication; may be asynchronous to stage release, sampled on clock.
- stage_reset  output  NUM_STAGES  active-high reset to each stage, registered.
- sys_ready  output  1  high while every stage is released and the sequence is complete.
- busy  output  1  high while a sequence is in progress.
- timeout_flag  output  1  sticky: some stage timed out in the current or last sequence.

Behaviour:
- During reset=0: stage_reset all 1, sys_ready=0, busy=1, timeout_flag=0, FSM=ASSERT, hold counter=0, init flag clear.
- After reset deasserts, a cold-boot sequence starts at once; no switch toggle is needed.
- Input path: 2-flop synchroniser on resetHW, then the debouncer.
- Debouncer:
  - Keeps an accepted level.
  - The first synchronised level after reset is adopted as the accepted level without generating a request; this sets the init flag.
  - Afterwards, a synchronised level different from the accepted level for DEBOUNCE_CYCLES consecutive cycles updates the accepted level and emits a 1-cycle req pulse.
  - Any bounce back restarts the count.
  - Latency from a clean edge to req: 2 + DEBOUNCE_CYCLES cycles.
  - Both edge directions request a sequence.
- FSM states:
  - ASSERT: stage_reset all 1, busy=1, sys_ready=0. Counts HOLD_CYCLES, then moves to RELEASE with k=0.
  - RELEASE(k): stage_reset[k] drops on entry, and stays 0 for all stages below k. Waits for stage_ready[k]=1, then k+1. Leaves for DONE after the last stage.
  - DONE: one cycle; busy falls, and sys_ready rises on the next cycle.
  - RUN: sys_ready=1, busy=0, stage_reset all 0. Stays here until req.
- req from the debouncer, in any state:
  - FSM goes to ASSERT on the next edge; all stage_reset go to 1 that cycle.
  - Hold counter restarts and timeout_flag clears.
  - This applies mid-sequence too; the restart takes priority over a simultaneous stage_ready.
- stage_ready[k] already high on entry to RELEASE(k): advance after exactly 1 cycle. Minimum dwell per stage is 1 cycle.
- stage_ready of stages not currently being waited on is ignored. A ready dropping after release has no effect.
- Counters are sized with $clog2(param+1) and saturate; no wrap.
- Asserting reset (low) mid-sequence immediately forces the reset values above.

Optional Feature:
- Macro: STAGE_TIMEOUT_EN.
- Defined:
  - RELEASE(k) counts cycles waiting for stage_ready.
  - At TIMEOUT_CYCLES, sets timeout_flag and advances to k+1; the stage stays released.
  - The flag stays set through RUN until the next ASSERT.
- Undefined:
  - RELEASE(k) waits indefinitely.
  - timeout_flag is tied 0 and no timeout counter is built.

Decomposition:
- Package snake_reset_pkg:
  - FSM state encoding (ASSERT, RELEASE, DONE, RUN).
  - Counter width helper function.
  - Default parameter constants.
- One sub-module, reset_debounce:
  - Contains the synchroniser, accepted-level register, init flag, stability counter and req pulse.
  - Parameter DEBOUNCE_CYCLES.

Test Plan:
Parameters: NUM_STAGES=3, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, TIMEOUT_CYCLES=16.
1. Cold boot: reset low 5 cycles then high, resetHW=0, stage_ready tied 3'b111 -> stage_reset 3'b111 for 8 cycles after the hold starts, then 3'b110, 3'b100, 3'b000 on consecutive cycles; sys_ready=1 two cycles after the last release.
2. Debounce: in RUN, resetHW toggles 0->1->0->1 at 2-cycle spacing, then holds 1 -> exactly one req, 2+4 cycles after the final edge; stage_reset 3'b111 next cycle. A 3-cycle glitch gives no req.
3. Handshake: stage_ready[1] held low 10 cycles after stage 1 release -> stage_reset stays 3'b100 for those 10 cycles, drops to 3'b000 the cycle after ready rises.
4. Restart mid-sequence: req arrives while in RELEASE(1) -> stage_reset returns to 3'b111 next cycle, busy stays 1, full 8-cycle hold re-runs.
5. Timeout (STAGE_TIMEOUT_EN): stage_ready[2] stuck 0 -> after 16 cycles timeout_flag=1, sys_ready=1. Next toggle clears timeout_flag at ASSERT. Without the macro, the sequence hangs with busy=1 and timeout_flag=0.
6. Async reset mid-RUN: reset low for half a cycle -> all outputs take reset values immediately, without waiting for a clock edge; the sequence restarts on release.
